// File: rtl/fetch_mem_responder_if.sv
`timescale 1ns/1ps
// Fetch channel bundle: address channel (core -> responder) and
// data channel (responder -> core), both valid/ready.
interface fetch_mem_responder_if #(
   parameter int unsigned XLEN = 64
);
   logic            fetch_addr_valid;
   logic [XLEN-1:0] fetch_addr;
   logic            fetch_addr_ready;
   logic            fetch_data_valid;
   logic [31:0]     fetch_data;
   logic            fetch_data_ready;

   // Core side
   modport master (
      output fetch_addr_valid,
      output fetch_addr,
      output fetch_data_ready,
      input  fetch_addr_ready,
      input  fetch_data_valid,
      input  fetch_data
   );

   // Responder side
   modport slave (
      input  fetch_addr_valid,
      input  fetch_addr,
      input  fetch_data_ready,
      output fetch_addr_ready,
      output fetch_data_valid,
      output fetch_data
   );
endinterface

// File: rtl/fetch_mem_responder.sv
`timescale 1ns/1ps
// fetch_mem_responder: stands in for the instruction cache/memory.
// Accepts fetch addresses, reads a word array at the accept edge, delays
// the word through a fixed-latency pipe and returns it in order through a
// small response FIFO. A simple load port fills the word array.
module fetch_mem_responder #(
   parameter int unsigned     XLEN            = 64,
   parameter logic [XLEN-1:0] BASE_ADDR       = 64'h8000_0000,
   parameter int unsigned     MEM_WORDS       = 4096,
   parameter int unsigned     LATENCY         = 2,
   parameter int unsigned     MAX_OUTSTANDING = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   fetch_mem_responder_if.slave bus,
   input  logic                 load_valid,
   input  logic [XLEN-1:0]      load_addr,
   input  logic [31:0]          load_data,
   output logic                 oob_o
);

   localparam int unsigned      IDX_W      = $clog2(MEM_WORDS);
   localparam int unsigned      CNT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned      PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [XLEN-1:0]  LIMIT_ADDR = BASE_ADDR + XLEN'(4 * MEM_WORDS);
   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_OUTSTANDING - 1);

   // Word array: no reset, contents survive rstn
   logic [31:0]      r_mem [MEM_WORDS];

   // Address decode
   logic [XLEN-1:0]  w_fa_off;
   logic [XLEN-1:0]  w_ld_off;
   logic             w_fa_in_range;
   logic             w_ld_in_range;
   logic [IDX_W-1:0] w_fa_idx;
   logic [IDX_W-1:0] w_ld_idx;

   // Handshakes and FIFO write side
   logic             w_accept;
   logic             w_pop;
   logic             w_push;
   logic [31:0]      w_push_data;

   // Outstanding tracking
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] w_outstanding_next;
   logic             r_addr_ready;
   logic             r_oob;

   // Response FIFO
   logic [31:0]      r_fifo_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_fifo_cnt;
   logic             w_fifo_valid;

   // ------------------------------------------------------------------
   // Decode: in range only when inside the window and word aligned
   // ------------------------------------------------------------------
   assign w_fa_off      = bus.fetch_addr - BASE_ADDR;
   assign w_fa_in_range = (bus.fetch_addr >= BASE_ADDR) &&
                          (bus.fetch_addr <  LIMIT_ADDR) &&
                          (bus.fetch_addr[1:0] == 2'b00);
   assign w_fa_idx      = IDX_W'(w_fa_off >> 2);

   assign w_ld_off      = load_addr - BASE_ADDR;
   assign w_ld_in_range = (load_addr >= BASE_ADDR) &&
                          (load_addr <  LIMIT_ADDR) &&
                          (load_addr[1:0] == 2'b00);
   assign w_ld_idx      = IDX_W'(w_ld_off >> 2);

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   assign w_accept     = bus.fetch_addr_valid && r_addr_ready;
   assign w_fifo_valid = (r_fifo_cnt != '0);
   assign w_pop        = w_fifo_valid && bus.fetch_data_ready;

   assign bus.fetch_addr_ready = r_addr_ready;
   assign bus.fetch_data_valid = w_fifo_valid;
   assign bus.fetch_data       = w_fifo_valid ? r_fifo_mem[r_rd_ptr] : 32'h0;
   assign oob_o                = r_oob;

   // Load port write; a fetch of the same word this edge sees the old value
   always_ff @(posedge clk) begin
      if (load_valid && w_ld_in_range) begin
         r_mem[w_ld_idx] <= load_data;
      end
   end

   // ------------------------------------------------------------------
   // Latency pipe. The FIFO register itself is the last of the LATENCY
   // stages, so the pipe ahead of it holds LATENCY-1 stages. With a
   // latency of one the word goes straight from the array into the FIFO.
   // ------------------------------------------------------------------
   generate
      if (LATENCY == 1) begin : g_direct
         assign w_push      = w_accept;
         assign w_push_data = w_fa_in_range ? r_mem[w_fa_idx] : 32'h0;
      end else begin : g_pipe
         localparam int unsigned STAGES = LATENCY - 1;
         logic [STAGES-1:0]       r_pipe_valid;
         logic [STAGES-1:0][31:0] r_pipe_data;

         // Valid bits shift every cycle; the pipe never stalls
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_pipe_valid <= '0;
            end else begin
               r_pipe_valid[0] <= w_accept;
               for (int i = 1; i < STAGES; i++) begin
                  r_pipe_valid[i] <= r_pipe_valid[i-1];
               end
            end
         end

         // Stage 0 is the registered array read taken at the accept edge
         always_ff @(posedge clk) begin
            if (w_accept) begin
               r_pipe_data[0] <= w_fa_in_range ? r_mem[w_fa_idx] : 32'h0;
            end
            for (int i = 1; i < STAGES; i++) begin
               r_pipe_data[i] <= r_pipe_data[i-1];
            end
         end

         assign w_push      = r_pipe_valid[STAGES-1];
         assign w_push_data = r_pipe_data[STAGES-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Outstanding count: pipe plus FIFO occupancy
   // ------------------------------------------------------------------
   always_comb begin
      w_outstanding_next = r_outstanding;
      case ({w_accept, w_pop})
         2'b10:   w_outstanding_next = r_outstanding + CNT_W'(1);
         2'b01:   w_outstanding_next = r_outstanding - CNT_W'(1);
         default: w_outstanding_next = r_outstanding;
      endcase
   end

   // Count, registered address ready (from next count) and sticky oob flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_outstanding <= '0;
         r_addr_ready  <= 1'b0;
         r_oob         <= 1'b0;
      end else begin
         r_outstanding <= w_outstanding_next;
         r_addr_ready  <= (w_outstanding_next < MAX_CNT);
         if (w_accept && !w_fa_in_range) begin
            r_oob <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response FIFO. Valid is derived from the registered count, so a word
   // pushed into an empty FIFO is visible only on the following cycle.
   // ------------------------------------------------------------------
   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // FIFO storage; the head is held until popped
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= w_push_data;
      end
   end

   // The outstanding bound covers pipe plus FIFO, so a push into a full
   // FIFO without a pop, or a count above the bound, is a design error
   a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
      !(w_push && !w_pop && (r_fifo_cnt == MAX_CNT)));
   a_bound : assert property (@(posedge clk) disable iff (!rstn)
      r_outstanding <= MAX_CNT);

endmodule

// File: tb/tb_fetch_mem_responder.sv
`timescale 1ns/1ps
// Testbench for fetch_mem_responder: scoreboard of expected words pushed at
// the address handshake, observed words captured at the data handshake.
module tb_fetch_mem_responder;

   localparam int unsigned XLEN      = 64;
   localparam logic [63:0] BASE      = 64'h8000_0000;
   localparam int unsigned MEM_WORDS = 4096;
   localparam int unsigned LATENCY   = 2;
   localparam int unsigned MAXO      = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        load_valid;
   logic [63:0] load_addr;
   logic [31:0] load_data;
   logic        oob_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_count = 0;

   logic [31:0] exp_data_q [$];
   int          exp_cyc_q  [$];
   logic [31:0] got_data_q [$];
   int          got_cyc_q  [$];
   logic [63:0] fetch_list [$];
   logic [31:0] model_mem  [int];

   fetch_mem_responder_if #(.XLEN(XLEN)) bus ();

   fetch_mem_responder #(
      .XLEN(XLEN), .BASE_ADDR(BASE), .MEM_WORDS(MEM_WORDS),
      .LATENCY(LATENCY), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .oob_o(oob_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit addr_ok(input logic [63:0] a);
      return (a >= BASE) && (a < BASE + 64'(4 * MEM_WORDS)) && (a[1:0] == 2'b00);
   endfunction

   function automatic int word_idx(input logic [63:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   // Scoreboard monitor: expected word from the pre-write model, then loads
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (bus.fetch_addr_valid && bus.fetch_addr_ready) begin
            exp_data_q.push_back(addr_ok(bus.fetch_addr) ? model_mem[word_idx(bus.fetch_addr)] : 32'h0);
            exp_cyc_q.push_back(cyc);
            acc_count++;
         end
         if (bus.fetch_data_valid && bus.fetch_data_ready) begin
            got_data_q.push_back(bus.fetch_data);
            got_cyc_q.push_back(cyc);
         end
         if (load_valid && addr_ok(load_addr))
            model_mem[word_idx(load_addr)] = load_data;
      end
   end

   task automatic clear_sb();
      exp_data_q.delete(); exp_cyc_q.delete();
      got_data_q.delete(); got_cyc_q.delete();
   endtask

   task automatic load_word(input logic [63:0] a, input logic [31:0] d);
      load_valid = 1'b1; load_addr = a; load_data = d;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   // Present fetch_list in order, advancing on each accept
   task automatic run_fetches(input int budget, output bit to);
      int start;
      start = acc_count;
      for (int i = 0; i < budget; i++) begin
         if (acc_count - start >= fetch_list.size()) break;
         bus.fetch_addr_valid = 1'b1;
         bus.fetch_addr = fetch_list[acc_count - start];
         @(posedge clk); #1;
      end
      bus.fetch_addr_valid = 1'b0;
      to = (acc_count - start < fetch_list.size());
   endtask

   task automatic wait_resp(input int n, input int budget, output bit to);
      int i = 0;
      while (got_data_q.size() < n && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      to = (got_data_q.size() < n);
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      total++; if (bus.fetch_addr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.fetch_addr_ready); end
      total++; if (bus.fetch_data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.fetch_data_valid); end
      total++; if (bus.fetch_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.fetch_data); end
      total++; if (oob_o !== 1'b0) begin bad++; $display("FAIL rst_oob got=%b want=0", oob_o); end
      rstn = 1'b1;
      total++; if (bus.fetch_addr_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_pre got=%b want=0", bus.fetch_addr_ready); end
      @(posedge clk); #1;
      total++; if (bus.fetch_addr_ready !== 1'b1) begin bad++; $display("FAIL rel_ready_post got=%b want=1", bus.fetch_addr_ready); end
   endtask

   task automatic test_single();
      bit to;
      bus.fetch_data_ready = 1'b1;
      load_word(BASE, 32'h0000_0513);
      clear_sb();
      bus.fetch_addr_valid = 1'b1; bus.fetch_addr = BASE;
      @(posedge clk); #1;
      bus.fetch_addr_valid = 1'b0;
      total++; if (bus.fetch_data_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", bus.fetch_data_valid); end
      @(posedge clk); #1;
      total++; if (bus.fetch_data_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.fetch_data_valid); end
      total++; if (bus.fetch_data !== 32'h0000_0513) begin bad++; $display("FAIL single_data got=%h want=00000513", bus.fetch_data); end
      @(posedge clk); #1;
      total++; if (bus.fetch_data_valid !== 1'b0 || bus.fetch_addr_ready !== 1'b1) begin
         bad++; $display("FAIL single_idle got valid=%b ready=%b want valid=0 ready=1", bus.fetch_data_valid, bus.fetch_addr_ready); end
      wait_resp(1, 10, to);
      total++; if (to) begin bad++; $display("FAIL single_timeout got=%0d want=1 responses", got_data_q.size()); end
      if (!to) begin
         total++; if (got_data_q[0] !== exp_data_q[0]) begin bad++; $display("FAIL single_sb got=%h want=%h", got_data_q[0], exp_data_q[0]); end
         total++; if (got_cyc_q[0] - exp_cyc_q[0] != LATENCY) begin bad++; $display("FAIL single_lat got=%0d want=%0d", got_cyc_q[0] - exp_cyc_q[0], LATENCY); end
      end
   endtask

   task automatic test_stream();
      bit to;
      int k;
      for (int i = 0; i < 8; i++) load_word(BASE + 64'(4 * i), 32'h100 + 32'(i));
      bus.fetch_data_ready = 1'b1;
      clear_sb();
      for (int i = 0; i < 8; i++) begin
         bus.fetch_addr_valid = 1'b1; bus.fetch_addr = BASE + 64'(4 * i);
         total++; if (bus.fetch_addr_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, bus.fetch_addr_ready); end
         @(posedge clk); #1;
      end
      bus.fetch_addr_valid = 1'b0;
      wait_resp(8, 20, to);
      total++; if (to) begin bad++; $display("FAIL stream_timeout got=%0d want=8", got_data_q.size()); end
      total++; if (got_cyc_q.size() > 0 && exp_cyc_q.size() > 0 && got_cyc_q[0] - exp_cyc_q[0] != LATENCY) begin
         bad++; $display("FAIL stream_lat got=%0d want=%0d", got_cyc_q[0] - exp_cyc_q[0], LATENCY); end
      k = 0;
      while (got_data_q.size() > 0 && exp_data_q.size() > 0) begin
         logic [31:0] g, e;
         int gc;
         g = got_data_q.pop_front(); e = exp_data_q.pop_front(); gc = got_cyc_q.pop_front();
         void'(exp_cyc_q.pop_front());
         total++; if (g !== e || g !== 32'h100 + 32'(k)) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", k, g, 32'h100 + 32'(k)); end
         if (k > 0) begin
            total++; if (gc != got_cyc_q.size() + gc - got_cyc_q.size()) begin end
         end
         k++;
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      int start;
      int first_cyc;
      logic [31:0] head;
      for (int i = 0; i < 8; i++) load_word(BASE + 64'(4 * (32 + i)), 32'h300 + 32'(i));
      bus.fetch_data_ready = 1'b1;
      clear_sb();
      fetch_list.delete();
      for (int i = 0; i < 8; i++) fetch_list.push_back(BASE + 64'(4 * (32 + i)));
      run_fetches(12, to);
      wait_resp(8, 20, to);
      total++; if (to) begin bad++; $display("FAIL b2b_timeout got=%0d want=8", got_data_q.size()); end
      first_cyc = (got_cyc_q.size() > 0) ? got_cyc_q[0] : 0;
      start = 0;
      while (got_data_q.size() > 0 && exp_data_q.size() > 0) begin
         int gc;
         head = got_data_q.pop_front(); gc = got_cyc_q.pop_front();
         void'(exp_cyc_q.pop_front());
         total++; if (head !== exp_data_q.pop_front()) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", start, head, 32'h300 + 32'(start)); end
         total++; if (gc != first_cyc + start) begin bad++; $display("FAIL b2b_cycle[%0d] got=%0d want=%0d", start, gc, first_cyc + start); end
         start++;
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int start;
      int k;
      logic [31:0] head;
      for (int i = 0; i < 6; i++) load_word(BASE + 64'(4 * (16 + i)), 32'h200 + 32'(i));
      bus.fetch_data_ready = 1'b0;
      clear_sb();
      fetch_list.delete();
      for (int i = 0; i < 6; i++) fetch_list.push_back(BASE + 64'(4 * (16 + i)));
      start = acc_count;
      run_fetches(12, to);
      total++; if (acc_count - start != 4) begin bad++; $display("FAIL bp_accepts got=%0d want=4", acc_count - start); end
      total++; if (bus.fetch_addr_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", bus.fetch_addr_ready); end
      total++; if (bus.fetch_data_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", bus.fetch_data_valid); end
      head = bus.fetch_data;
      total++; if (head !== 32'h200) begin bad++; $display("FAIL bp_head got=%h want=00000200", head); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (bus.fetch_data !== 32'h200) begin bad++; $display("FAIL bp_stable[%0d] got=%h want=00000200", i, bus.fetch_data); end
      end
      bus.fetch_data_ready = 1'b1;
      void'(fetch_list.pop_front()); void'(fetch_list.pop_front());
      void'(fetch_list.pop_front()); void'(fetch_list.pop_front());
      run_fetches(20, to);
      total++; if (to) begin bad++; $display("FAIL bp_rest_timeout got=%0d want=6 accepts", acc_count - start); end
      wait_resp(6, 30, to);
      total++; if (to) begin bad++; $display("FAIL bp_resp_timeout got=%0d want=6", got_data_q.size()); end
      total++; if (exp_cyc_q.size() > 4 && got_cyc_q.size() > 0 && exp_cyc_q[4] <= got_cyc_q[0]) begin
         bad++; $display("FAIL bp_order got=5th accept cyc %0d want after first return cyc %0d", exp_cyc_q[4], got_cyc_q[0]); end
      k = 0;
      while (got_data_q.size() > 0 && exp_data_q.size() > 0) begin
         logic [31:0] g, e;
         g = got_data_q.pop_front(); e = exp_data_q.pop_front();
         total++; if (g !== e || g !== 32'h200 + 32'(k)) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", k, g, 32'h200 + 32'(k)); end
         k++;
      end
   endtask

   task automatic test_oob();
      bit to;
      int k;
      bus.fetch_data_ready = 1'b1;
      clear_sb();
      total++; if (oob_o !== 1'b0) begin bad++; $display("FAIL oob_pre got=%b want=0", oob_o); end
      bus.fetch_addr_valid = 1'b1; bus.fetch_addr = 64'h7FFF_FFFC;
      @(posedge clk); #1;
      bus.fetch_addr_valid = 1'b0;
      total++; if (oob_o !== 1'b1) begin bad++; $display("FAIL oob_set got=%b want=1", oob_o); end
      fetch_list.delete();
      fetch_list.push_back(64'h8000_0002);
      fetch_list.push_back(64'h8000_4000);
      run_fetches(10, to);
      wait_resp(3, 20, to);
      total++; if (to) begin bad++; $display("FAIL oob_timeout got=%0d want=3", got_data_q.size()); end
      k = 0;
      while (got_data_q.size() > 0 && exp_data_q.size() > 0) begin
         logic [31:0] g, e;
         g = got_data_q.pop_front(); e = exp_data_q.pop_front();
         total++; if (g !== e || g !== 32'h0) begin bad++; $display("FAIL oob_data[%0d] got=%h want=00000000", k, g); end
         k++;
      end
      total++; if (oob_o !== 1'b1) begin bad++; $display("FAIL oob_sticky got=%b want=1", oob_o); end
   endtask

   task automatic test_reset_midflight();
      bit to;
      bus.fetch_data_ready = 1'b0;
      clear_sb();
      fetch_list.delete();
      for (int i = 0; i < 3; i++) fetch_list.push_back(BASE + 64'(4 * i));
      run_fetches(10, to);
      total++; if (to) begin bad++; $display("FAIL mid_accept_timeout got=%0d want=3", exp_data_q.size()); end
      rstn = 1'b0;
      #1;
      total++; if (bus.fetch_data_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", bus.fetch_data_valid); end
      total++; if (bus.fetch_addr_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", bus.fetch_addr_ready); end
      total++; if (oob_o !== 1'b0) begin bad++; $display("FAIL mid_oob got=%b want=0", oob_o); end
      @(posedge clk); #1;
      rstn = 1'b1;
      clear_sb();
      bus.fetch_data_ready = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      total++; if (got_data_q.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0 responses", got_data_q.size()); end
      load_word(64'h9000_0000, 32'hFFFF_FFFF);
      total++; if (oob_o !== 1'b0) begin bad++; $display("FAIL mid_load_oob got=%b want=0", oob_o); end
      fetch_list.delete();
      fetch_list.push_back(BASE + 64'd12);
      run_fetches(10, to);
      wait_resp(1, 10, to);
      total++; if (to) begin bad++; $display("FAIL mid_retain_timeout got=%0d want=1", got_data_q.size()); end
      if (!to) begin
         total++; if (got_data_q[0] !== 32'h103 || got_data_q[0] !== exp_data_q[0]) begin
            bad++; $display("FAIL mid_retain got=%h want=00000103", got_data_q[0]); end
      end
   endtask

   task automatic test_same_cycle();
      bit to;
      bus.fetch_data_ready = 1'b1;
      load_word(BASE + 64'h14, 32'h0000_0013);
      clear_sb();
      load_valid = 1'b1; load_addr = BASE + 64'h14; load_data = 32'hDEAD_BEEF;
      bus.fetch_addr_valid = 1'b1; bus.fetch_addr = BASE + 64'h14;
      total++; if (bus.fetch_addr_ready !== 1'b1) begin bad++; $display("FAIL same_ready got=%b want=1", bus.fetch_addr_ready); end
      @(posedge clk); #1;
      load_valid = 1'b0; bus.fetch_addr_valid = 1'b0;
      fetch_list.delete();
      fetch_list.push_back(BASE + 64'h14);
      run_fetches(10, to);
      wait_resp(2, 20, to);
      total++; if (to) begin bad++; $display("FAIL same_timeout got=%0d want=2", got_data_q.size()); end
      if (!to) begin
         total++; if (got_data_q[0] !== 32'h13 || got_data_q[0] !== exp_data_q[0]) begin
            bad++; $display("FAIL same_old got=%h want=00000013", got_data_q[0]); end
         total++; if (got_data_q[1] !== 32'hDEAD_BEEF || got_data_q[1] !== exp_data_q[1]) begin
            bad++; $display("FAIL same_new got=%h want=deadbeef", got_data_q[1]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b1;
      load_valid = 1'b0; load_addr = '0; load_data = '0;
      bus.fetch_addr_valid = 1'b0; bus.fetch_addr = '0; bus.fetch_data_ready = 1'b0;
      #2 rstn = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_back_to_back();
      test_backpressure();
      test_oob();
      test_reset_midflight();
      test_same_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
